keypad_tone_engine: RTL

//  Parametrised successor of the keypad-to-buzzer path: scans a ROWS x COLS matrix keypad,

---
 rtl/keypad_pkg.sv | 26 ++
 rtl/kp_scan_debounce.sv | 124 ++++++++++++
 rtl/keypad_tone_engine.sv | 102 ++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - tone table, FSM encoding and width helpers for the keypad tone engine
package keypad_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_HOLD  = 2'd1,
      ST_TIMED = 2'd2
   } tone_state_e;

   localparam int TONE_KEYS = 16;

   // Buzzer half-periods in 50 MHz clocks, C4 (key 0) up to D#5 (key 15)
   localparam int TONE_TABLE_50M [TONE_KEYS] = '{
      95555, 90194, 85132, 80352, 75843, 71586, 67569, 63776,
      60197, 56818, 53630, 50620, 47778, 45096, 42566, 40177
   };

   function automatic int kp_key_w(input int rows, input int cols);
      return (rows * cols > 1) ? $clog2(rows * cols) : 1;
   endfunction

   function automatic int kp_cnt_w(input int limit);
      return (limit > 1) ? $clog2(limit) : 1;
   endfunction

endpackage

// File: rtl/kp_scan_debounce.sv
// rtl/kp_scan_debounce.sv - keypad row scanner with column synchroniser and whole-frame debounce
module kp_scan_debounce
   import keypad_pkg::*;
#(
   parameter int CLK_HZ          = 50_000_000,
   parameter int SCAN_HZ         = 1_000,
   parameter int ROWS            = 4,
   parameter int COLS            = 4,
   parameter int DEBOUNCE_FRAMES = 4,
   localparam int KEY_W          = kp_key_w(ROWS, COLS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [COLS-1:0]  col,
   output logic [ROWS-1:0]  row,
   output logic [KEY_W-1:0] key_code,
   output logic             key_valid,
   output logic             key_pressed
);
   localparam int SLOT_CLKS = CLK_HZ / SCAN_HZ;
   localparam int PRE_W     = kp_cnt_w(SLOT_CLKS);
   localparam int ROW_W     = kp_cnt_w(ROWS);
   localparam int MATCH_W   = kp_cnt_w(DEBOUNCE_FRAMES + 1);

   logic [PRE_W-1:0]   pre_q, pre_d;
   logic [ROW_W-1:0]   row_idx_q, row_idx_d;
   logic [COLS-1:0]    sync1_q, sync1_d, sync2_q, sync2_d;
   logic               frame_hit_q, frame_hit_d, prev_hit_q, prev_hit_d;
   logic [KEY_W-1:0]   frame_key_q, frame_key_d, prev_key_q, prev_key_d;
   logic [MATCH_W-1:0] match_q, match_d;
   logic               valid_q, valid_d, pressed_q, pressed_d;
   logic [KEY_W-1:0]   code_q, code_d;
   logic               tick, slot_hit, cand_hit, same;
   logic [KEY_W-1:0]   slot_key, cand_key;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre_q       <= '0;
         row_idx_q   <= '0;
         sync1_q     <= '1;
         sync2_q     <= '1;
         frame_hit_q <= 1'b0;
         frame_key_q <= '0;
         prev_hit_q  <= 1'b0;
         prev_key_q  <= '0;
         match_q     <= '0;
         valid_q     <= 1'b0;
         code_q      <= '0;
         pressed_q   <= 1'b0;
      end else begin
         pre_q       <= pre_d;
         row_idx_q   <= row_idx_d;
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         frame_hit_q <= frame_hit_d;
         frame_key_q <= frame_key_d;
         prev_hit_q  <= prev_hit_d;
         prev_key_q  <= prev_key_d;
         match_q     <= match_d;
         valid_q     <= valid_d;
         code_q      <= code_d;
         pressed_q   <= pressed_d;
      end
   end

   always_comb begin
      sync1_d  = col;
      sync2_d  = sync1_q;
      tick     = (pre_q == PRE_W'(SLOT_CLKS - 1));
      pre_d    = tick ? '0 : pre_q + 1'b1;
      slot_hit = 1'b0;
      slot_key = '0;
      for (int c = COLS - 1; c >= 0; c--) begin
         if (!sync2_q[c]) begin
            slot_hit = 1'b1;
            slot_key = KEY_W'(int'(row_idx_q) * COLS + c);
         end
      end
      // Rows are scanned in ascending order, so an earlier hit in the frame is the lower index
      cand_hit    = frame_hit_q | slot_hit;
      cand_key    = frame_hit_q ? frame_key_q : slot_key;
      same        = 1'b0;
      row_idx_d   = row_idx_q;
      frame_hit_d = frame_hit_q;
      frame_key_d = frame_key_q;
      prev_hit_d  = prev_hit_q;
      prev_key_d  = prev_key_q;
      match_d     = match_q;
      valid_d     = valid_q;
      code_d      = code_q;
      pressed_d   = 1'b0;
      if (tick) begin
         if (row_idx_q == ROW_W'(ROWS - 1)) begin
            row_idx_d   = '0;
            frame_hit_d = 1'b0;
            frame_key_d = '0;
            prev_hit_d  = cand_hit;
            prev_key_d  = cand_key;
            same        = (cand_hit == prev_hit_q) && (!cand_hit || cand_key == prev_key_q);
            if (!same)
               match_d = MATCH_W'(1);
            else if (match_q != MATCH_W'(DEBOUNCE_FRAMES))
               match_d = match_q + 1'b1;
            if (match_d == MATCH_W'(DEBOUNCE_FRAMES) &&
                (cand_hit != valid_q || (cand_hit && cand_key != code_q))) begin
               valid_d   = cand_hit;
               pressed_d = cand_hit;
               if (cand_hit)
                  code_d = cand_key;
            end
         end else begin
            row_idx_d   = row_idx_q + 1'b1;
            frame_hit_d = cand_hit;
            frame_key_d = cand_key;
         end
      end
   end

   assign row         = ~(ROWS'(1) << row_idx_q);
   assign key_code    = code_q;
   assign key_valid   = valid_q;
   assign key_pressed = pressed_q;

endmodule

// File: rtl/keypad_tone_engine.sv
// rtl/keypad_tone_engine.sv - keypad to square-wave buzzer with hold / one-shot play modes
module keypad_tone_engine
   import keypad_pkg::*;
#(
   parameter int CLK_HZ                 = 50_000_000,
   parameter int SCAN_HZ                = 1_000,
   parameter int ROWS                   = 4,
   parameter int COLS                   = 4,
   parameter int DEBOUNCE_FRAMES        = 4,
   parameter int DIV_W                  = 17,
   parameter int NOTE_MS                = 200,
   parameter int TONE_TABLE [TONE_KEYS] = TONE_TABLE_50M,
   localparam int KEY_W                 = kp_key_w(ROWS, COLS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [COLS-1:0]  col,
   input  logic             mode,
   input  logic [1:0]       octave,
   output logic [ROWS-1:0]  row,
   output logic [KEY_W-1:0] key_code,
   output logic             key_valid,
   output logic             key_pressed,
   output logic             busy,
   output logic             out_buzzer
);
   localparam int NOTE_CLKS = int'(longint'(NOTE_MS) * longint'(CLK_HZ) / 64'd1000);
   localparam int MS_W      = kp_cnt_w(NOTE_CLKS);

   tone_state_e      state_q, state_d;
   logic [DIV_W-1:0] nh_q, nh_d, tone_q, tone_d, nh_new;
   logic [MS_W-1:0]  ms_q, ms_d;
   logic             buzz_q, buzz_d;
   logic [3:0]       tbl_idx;

   kp_scan_debounce #(
      .CLK_HZ          (CLK_HZ),
      .SCAN_HZ         (SCAN_HZ),
      .ROWS            (ROWS),
      .COLS            (COLS),
      .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES)
   ) u_scan (
      .clk         (clk),
      .rst         (rst),
      .col         (col),
      .row         (row),
      .key_code    (key_code),
      .key_valid   (key_valid),
      .key_pressed (key_pressed)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         nh_q    <= '0;
         tone_q  <= '0;
         ms_q    <= '0;
         buzz_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         nh_q    <= nh_d;
         tone_q  <= tone_d;
         ms_q    <= ms_d;
         buzz_q  <= buzz_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (key_pressed) state_d = mode ? ST_TIMED : ST_HOLD;
         ST_HOLD:  if (!key_valid) state_d = ST_IDLE;
         // A press landing on the expiry clock retriggers instead of ending the note
         ST_TIMED: if (!key_pressed && ms_q == MS_W'(NOTE_CLKS - 1)) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      tbl_idx = 4'(key_code);
      nh_new  = DIV_W'(TONE_TABLE[tbl_idx]) >> octave;
      nh_d    = key_pressed ? nh_new : nh_q;
      ms_d    = '0;
      tone_d  = '0;
      buzz_d  = 1'b0;
      if (state_d == ST_TIMED && !key_pressed)
         ms_d = ms_q + 1'b1;
      if (state_d != ST_IDLE && nh_d != '0) begin
         buzz_d = buzz_q;
         if (!key_pressed) begin
            if (tone_q == nh_q - 1'b1)
               buzz_d = ~buzz_q;
            else
               tone_d = tone_q + 1'b1;
         end
      end
   end

   assign busy       = (state_q != ST_IDLE) && (nh_q != '0);
   assign out_buzzer = buzz_q;

endmodule
